mc_controller: RTL and testbench

Parametrised multi-core sequencing controller for the matrix-multiplication datapath. Runs a fixed fetch/decode/execute state machine over the instruction presented on `IR` and drives named control strobes to the PC, memory, and N_CORES parallel ALU cores. It adds to the earlier fixed-width controller: configurable memory wait states, combined zero flags from all cores, start/done handshake, illegal-opcode flagging and a cycle counter.

---
 rtl/mc_controller.sv | 181 ++++++++++++++++++
 tb/tb_mc_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-core fetch/decode/execute sequencing controller
// Moore strobes decoded from state, wait counter and the opcode/zero flag latched in DECODE.
module mc_controller #(
  parameter int IR_W    = 16,
  parameter int OPC_W   = 8,
  parameter int N_CORES = 4,
  parameter int MEM_LAT = 2,
  parameter int Z_MODE  = 0,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IR_W-1:0]    IR,
  input  logic [N_CORES-1:0] z,
  output logic               fetch_rd,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               mem_rd,
  output logic               reg_ld,
  output logic               mem_wr,
  output logic               alu_en,
  output logic [2:0]         alu_op,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int WC_W = $clog2(MEM_LAT) + 1;
  localparam logic [WC_W-1:0] FETCH_LAST = WC_W'(MEM_LAT - 1);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDA   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_STA   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_INC   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JMPNZ = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP   = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_END   = OPC_W'(8);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOADIR, S_DECODE, S_EXEC, S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic               zc_q, zc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zc_now;

  assign zc_now      = (Z_MODE != 0) ? (|z) : (&z);
  assign busy        = (state_q != S_IDLE);
  assign cycle_count = cnt_q;

  if (IR_W > OPC_W) begin : g_ir_hi
    logic unused_ir_hi;
    assign unused_ir_hi = ^IR[IR_W-1:OPC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      opc_q   <= '0;
      zc_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      opc_q   <= opc_d;
      zc_q    <= zc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    opc_d    = opc_q;
    zc_d     = zc_q;
    cnt_d    = cnt_q;
    fetch_rd = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mem_rd   = 1'b0;
    reg_ld   = 1'b0;
    mem_wr   = 1'b0;
    alu_en   = 1'b0;
    alu_op   = 3'd0;
    done     = 1'b0;
    err      = 1'b0;

    // Busy-cycle counter saturates rather than wrapping.
    if (state_q != S_IDLE && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wcnt_d  = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        fetch_rd = 1'b1;
        if (wcnt_q == FETCH_LAST) begin
          wcnt_d  = '0;
          state_d = S_LOADIR;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      S_LOADIR: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        opc_d   = IR[OPC_W-1:0];
        zc_d    = zc_now;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opc_q)
          OP_NOP: begin
          end
          OP_LDA: begin
            mem_rd = 1'b1;
            if (MEM_LAT == 1) begin
              reg_ld = 1'b1;
            end else begin
              wcnt_d  = '0;
              state_d = S_WAIT;
            end
          end
          OP_STA:   mem_wr = 1'b1;
          OP_ADD: begin
            alu_en = 1'b1;
            alu_op = 3'd0;
          end
          OP_MUL: begin
            alu_en = 1'b1;
            alu_op = 3'd1;
          end
          OP_INC: begin
            alu_en = 1'b1;
            alu_op = 3'd2;
          end
          OP_JMPNZ: pc_load = ~zc_q;
          OP_JMP:   pc_load = 1'b1;
          OP_END: begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
          default:  err = 1'b1;
        endcase
      end
      S_WAIT: begin
        mem_rd = 1'b1;
        if (wcnt_q == WAIT_LAST) begin
          reg_ld  = 1'b1;
          wcnt_d  = '0;
          state_d = S_FETCH;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
// Two builds: MEM_LAT=2 (32-bit counter) and MEM_LAT=1 (4-bit counter to reach saturation).
module tb_mc_controller;
  localparam int ML0 = 2;
  localparam int ML1 = 1;
  localparam int CW1 = 4;

  localparam logic [13:0] V_F    = 14'h2000;
  localparam logic [13:0] V_IRLD = 14'h1000;
  localparam logic [13:0] V_PCI  = 14'h0800;
  localparam logic [13:0] V_PCLD = 14'h0400;
  localparam logic [13:0] V_MRD  = 14'h0200;
  localparam logic [13:0] V_RLD  = 14'h0100;
  localparam logic [13:0] V_MWR  = 14'h0080;
  localparam logic [13:0] V_ALU  = 14'h0040;
  localparam logic [13:0] V_OP1  = 14'h0008;
  localparam logic [13:0] V_OP2  = 14'h0010;
  localparam logic [13:0] V_B    = 14'h0004;
  localparam logic [13:0] V_DONE = 14'h0002;
  localparam logic [13:0] V_ERR  = 14'h0001;

  typedef struct {
    logic [13:0] v;
    int          idx;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1;
  logic [15:0] IR;
  logic [3:0]  z;

  logic fetch_rd0, ir_load0, pc_inc0, pc_load0, mem_rd0, reg_ld0, mem_wr0, alu_en0, busy0, done0, err0;
  logic fetch_rd1, ir_load1, pc_inc1, pc_load1, mem_rd1, reg_ld1, mem_wr1, alu_en1, busy1, done1, err1;
  logic [2:0]     alu_op0, alu_op1;
  logic [31:0]    cc0;
  logic [CW1-1:0] cc1;
  logic [13:0]    vec0, vec1;

  mc_controller #(.MEM_LAT(ML0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .IR(IR), .z(z),
    .fetch_rd(fetch_rd0), .ir_load(ir_load0), .pc_inc(pc_inc0), .pc_load(pc_load0),
    .mem_rd(mem_rd0), .reg_ld(reg_ld0), .mem_wr(mem_wr0), .alu_en(alu_en0),
    .alu_op(alu_op0), .busy(busy0), .done(done0), .err(err0), .cycle_count(cc0)
  );

  mc_controller #(.MEM_LAT(ML1), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .IR(IR), .z(z),
    .fetch_rd(fetch_rd1), .ir_load(ir_load1), .pc_inc(pc_inc1), .pc_load(pc_load1),
    .mem_rd(mem_rd1), .reg_ld(reg_ld1), .mem_wr(mem_wr1), .alu_en(alu_en1),
    .alu_op(alu_op1), .busy(busy1), .done(done1), .err(err1), .cycle_count(cc1)
  );

  // alu_op is only meaningful while alu_en is high.
  assign vec0 = {fetch_rd0, ir_load0, pc_inc0, pc_load0, mem_rd0, reg_ld0, mem_wr0, alu_en0,
                 alu_en0 ? alu_op0 : 3'd0, busy0, done0, err0};
  assign vec1 = {fetch_rd1, ir_load1, pc_inc1, pc_load1, mem_rd1, reg_ld1, mem_wr1, alu_en1,
                 alu_en1 ? alu_op1 : 3'd0, busy1, done1, err1};

  int          n_checks = 0;
  int          n_errors = 0;
  sb_t         sb[$];
  int          sb_idx   = 0;
  int          exp_busy = 0;
  logic [15:0] prog_op[$];
  logic [3:0]  prog_z[$];
  bit          sel      = 1'b0;
  int          pc       = 0;
  int          since    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [13:0] v);
    sb.push_back('{v, sb_idx});
    sb_idx++;
    if (v[2]) exp_busy++;
  endtask

  task automatic push_prog(input int ml);
    exp_busy = 0;
    foreach (prog_op[i]) begin
      logic [7:0] op;
      op = prog_op[i][7:0];
      for (int k = 0; k < ml; k++) push1(V_F | V_B);
      push1(V_IRLD | V_PCI | V_B);
      push1(V_B);
      case (op)
        8'd0: push1(V_B);
        8'd1: begin
          if (ml == 1) push1(V_MRD | V_RLD | V_B);
          else begin
            push1(V_MRD | V_B);
            for (int k = 1; k < ml; k++) push1(V_MRD | V_B | ((k == ml - 1) ? V_RLD : 14'h0));
          end
        end
        8'd2: push1(V_MWR | V_B);
        8'd3: push1(V_ALU | V_B);
        8'd4: push1(V_ALU | V_OP1 | V_B);
        8'd5: push1(V_ALU | V_OP2 | V_B);
        8'd6: push1(((&prog_z[i]) ? 14'h0 : V_PCLD) | V_B);
        8'd7: push1(V_PCLD | V_B);
        8'd8: begin
          push1(V_DONE | V_B);
          push1(14'h0);
        end
        default: push1(V_ERR | V_B);
      endcase
    end
  endtask

  // Instruction memory responds to ir_load; inputs are scrambled during EXEC to prove latching.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check_eq($sformatf("seq%0d", e.idx), {18'd0, (sel ? vec1 : vec0)}, {18'd0, e.v});
    end
    if (sel ? ir_load1 : ir_load0) begin
      if (pc < prog_op.size()) begin
        IR = prog_op[pc];
        z  = prog_z[pc];
      end
      pc++;
      since = 1;
    end else begin
      if (since == 2) begin
        z  = 4'b1111;
        IR = 16'h00FF;
      end
      since++;
    end
  end

  task automatic run_prog(input bit s, input bit poke);
    int cc_exp;
    sel = s;
    pc  = 0;
    @(posedge clk); #1;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    push_prog(s ? ML1 : ML0);
    for (int k = 0; k < 600 && sb.size() > 0; k++) begin
      if (poke && k == 3) begin
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      if (poke && k == 4) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    start1 = 1'b0;
    if (sb.size() != 0) begin
      check_eq("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    cc_exp = s ? ((exp_busy > 15) ? 15 : exp_busy) : exp_busy;
    check_eq("cycle_count", s ? {28'd0, cc1} : cc0, cc_exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1; IR = '0; z = '0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_vec0", {18'd0, vec0}, 32'd0);
      check_eq("rst_cc0", cc0, 32'd0);
      check_eq("rst_vec1", {18'd0, vec1}, 32'd0);
    end
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("idle_vec0", {18'd0, vec0}, 32'd0);
      check_eq("idle_busy1", {31'd0, busy1}, 32'd0);
    end

    prog_op = '{16'h0000, 16'h0003, 16'h00FF, 16'h0008};
    prog_z  = '{4'hF, 4'hF, 4'hF, 4'hF};
    run_prog(1'b0, 1'b0);
    check_eq("cc_prog_a_20", cc0, 32'd20);

    prog_op = '{16'h0006, 16'h0006, 16'h0001, 16'h0002, 16'h0004, 16'h0005, 16'h0007, 16'h0009, 16'h1208};
    prog_z  = '{4'b1111, 4'b0111, 4'h0, 4'h5, 4'hF, 4'h1, 4'h0, 4'hF, 4'h3};
    run_prog(1'b0, 1'b1);

    prog_op = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0008};
    prog_z  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_prog(1'b1, 1'b0);
    check_eq("cc_sat_15", {28'd0, cc1}, 32'd15);

    prog_op = '{16'h0001, 16'h0008};
    prog_z  = '{4'h0, 4'h0};
    sel = 1'b0;
    pc  = 0;
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    push_prog(ML0);
    while (sb.size() > 6) void'(sb.pop_back());
    push1(14'h0);
    push1(14'h0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    check_eq("wait_rst_drained", sb.size(), 0);
    sb.delete();
    check_eq("wait_rst_cc", cc0, 32'd0);

    run_prog(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
